// File: rtl/symm_conv_check.sv
// symm_conv_check: FastICA convergence test; row dot products of W_new against W_old, max |1-|d||, iteration count, W_old retirement
module symm_conv_check #(
  parameter int FRAC     = 16,
  parameter int TOL      = 66,
  parameter int MAX_ITER = 100
) (
  input  logic         clk_conv,
  input  logic         rstn_conv,
  input  logic         go_conv,
  input  logic         init_conv,
  input  logic [415:0] w_new_flat,
  output logic         conv_busy,
  output logic         conv_done,
  output logic         converged,
  output logic         iter_limit,
  output logic [7:0]   iter_cnt,
  output logic [25:0]  delta_max,
  output logic [415:0] w_old_flat
);
  typedef enum logic [1:0] {IDLE, MAC, EVAL, FINISH} state_t;
  localparam logic signed [53:0] D_MAX = 54'sd33554431;
  localparam logic signed [53:0] D_MIN = -54'sd33554432;
  localparam logic [25:0] ONE = 26'd1 << FRAC;
  state_t state_q, state_d;
  logic [415:0] w_new_q, w_new_d, w_old_q, w_old_d;
  logic w_old_valid_q, w_old_valid_d;
  logic signed [53:0] acc_q, acc_d;
  logic [1:0] row_q, row_d, col_q, col_d;
  logic [25:0] delta_max_q, delta_max_d;
  logic converged_q, converged_d, iter_limit_q, iter_limit_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [7:0] iter_cnt_q, iter_cnt_d, iter_inc;
  logic signed [25:0] a_el, b_el, d;
  logic signed [51:0] prod;
  logic signed [53:0] shifted;
  logic signed [26:0] diff;
  logic [25:0] mag, delta;
  always_comb begin
    a_el = w_new_q[int'({row_q, col_q}) * 26 +: 26];
    b_el = w_old_q[int'({row_q, col_q}) * 26 +: 26];
    prod = a_el * b_el;
    shifted = acc_q >>> FRAC;
    d = shifted > D_MAX ? D_MAX[25:0] : shifted < D_MIN ? D_MIN[25:0] : shifted[25:0];
    // -2^25 has no positive twin in 26 bits, so its magnitude clamps to 2^25-1
    mag = (d[25] && d[24:0] == '0) ? 26'h1FFFFFF : d[25] ? 26'(-d) : 26'(d);
    diff = $signed({1'b0, ONE}) - $signed({1'b0, mag});
    delta = diff[26] ? 26'(-diff) : diff[25:0];
    iter_inc = iter_cnt_q == 8'hFF ? 8'hFF : iter_cnt_q + 8'd1;
    state_d = state_q;
    w_new_d = w_new_q;
    w_old_d = w_old_q;
    w_old_valid_d = w_old_valid_q;
    acc_d = acc_q;
    row_d = row_q;
    col_d = col_q;
    delta_max_d = delta_max_q;
    converged_d = converged_q;
    iter_limit_d = iter_limit_q;
    iter_cnt_d = iter_cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_conv) begin
          w_old_valid_d = 1'b0;
          iter_cnt_d = '0;
        end
        if (go_conv) begin
          w_new_d = w_new_flat;
          acc_d = '0;
          row_d = '0;
          col_d = '0;
          delta_max_d = '0;
          busy_d = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + 54'(prod);
        col_d = col_q + 2'd1;
        state_d = col_q == 2'd3 ? EVAL : MAC;
      end
      EVAL: begin
        delta_max_d = delta > delta_max_q ? delta : delta_max_q;
        acc_d = '0;
        row_d = row_q == 2'd3 ? row_q : row_q + 2'd1;
        col_d = '0;
        state_d = row_q == 2'd3 ? FINISH : MAC;
      end
      FINISH: begin
        converged_d = w_old_valid_q && (int'(delta_max_q) < TOL);
        iter_cnt_d = iter_inc;
        iter_limit_d = int'(iter_inc) >= MAX_ITER;
        w_old_d = w_new_q;
        w_old_valid_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_conv or negedge rstn_conv) begin
    if (!rstn_conv) begin
      state_q <= IDLE;
      w_new_q <= '0;
      w_old_q <= '0;
      w_old_valid_q <= 1'b0;
      acc_q <= '0;
      row_q <= '0;
      col_q <= '0;
      delta_max_q <= '0;
      converged_q <= 1'b0;
      iter_limit_q <= 1'b0;
      iter_cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_new_q <= w_new_d;
      w_old_q <= w_old_d;
      w_old_valid_q <= w_old_valid_d;
      acc_q <= acc_d;
      row_q <= row_d;
      col_q <= col_d;
      delta_max_q <= delta_max_d;
      converged_q <= converged_d;
      iter_limit_q <= iter_limit_d;
      iter_cnt_q <= iter_cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign conv_busy = busy_q;
  assign conv_done = done_q;
  assign converged = converged_q;
  assign iter_limit = iter_limit_q;
  assign iter_cnt = iter_cnt_q;
  assign delta_max = delta_max_q;
  assign w_old_flat = w_old_q;
endmodule

// File: tb/tb_symm_conv_check.sv
// tb_symm_conv_check: directed and random checks of symm_conv_check against a matrix-level reference model
module tb_symm_conv_check;
  localparam int MAXI = 3;
  logic clk_conv = 1'b0;
  logic rstn_conv = 1'b0;
  logic go_conv = 1'b0;
  logic init_conv = 1'b0;
  logic [415:0] w_new_flat = '0;
  logic conv_busy, conv_done, converged, iter_limit;
  logic [7:0] iter_cnt;
  logic [25:0] delta_max;
  logic [415:0] w_old_flat;
  int tests = 0;
  int fails = 0;
  longint mo[16];
  logic [415:0] mold;
  bit mvalid, mlim, mconv;
  int mcnt;
  longint mdmax;
  always #5 clk_conv = ~clk_conv;
  symm_conv_check #(.MAX_ITER(MAXI)) dut (
    .clk_conv(clk_conv), .rstn_conv(rstn_conv), .go_conv(go_conv), .init_conv(init_conv),
    .w_new_flat(w_new_flat), .conv_busy(conv_busy), .conv_done(conv_done), .converged(converged),
    .iter_limit(iter_limit), .iter_cnt(iter_cnt), .delta_max(delta_max), .w_old_flat(w_old_flat)
  );
  task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic longint el(input logic [415:0] w, input int k);
    return longint'($signed(w[k*26 +: 26]));
  endfunction
  function automatic logic [415:0] diag(input longint v);
    logic [415:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[5*i*26 +: 26] = 26'(v);
    return w;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 16; k++) mo[k] = 0;
    mold = '0;
    mvalid = 0;
    mcnt = 0;
    mlim = 0;
  endtask
  task automatic model(input logic [415:0] w);
    longint s, dd, a, dl;
    mdmax = 0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += el(w, 4*i+j) * mo[4*i+j];
      dd = s >>> 16;
      if (dd > 33554431) dd = 33554431;
      if (dd < -33554432) dd = -33554432;
      a = dd < 0 ? -dd : dd;
      if (a > 33554431) a = 33554431;
      dl = 65536 - a;
      if (dl < 0) dl = -dl;
      if (dl > mdmax) mdmax = dl;
    end
    mconv = mvalid && mdmax < 66;
    mcnt = mcnt < 255 ? mcnt + 1 : 255;
    mlim = mcnt >= MAXI;
    for (int k = 0; k < 16; k++) mo[k] = el(w, k);
    mold = w;
    mvalid = 1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, conv_busy, 0);
    chk({tag, " done"}, conv_done, 0);
    chk({tag, " converged"}, converged, 0);
    chk({tag, " iter_limit"}, iter_limit, 0);
    chk({tag, " iter_cnt"}, iter_cnt, 0);
    chk({tag, " delta_max"}, delta_max, 0);
    chk({tag, " w_old"}, w_old_flat, 0);
  endtask
  task automatic run(input string tag, input logic [415:0] w, input bit b2b, input bit ghost);
    int lat;
    bit busy_ok;
    if (!b2b) begin
      @(negedge clk_conv);
      chk({tag, " done-pulse-width"}, conv_done, 0);
    end
    go_conv = 1'b1;
    w_new_flat = w;
    @(negedge clk_conv);
    go_conv = 1'b0;
    w_new_flat = {13{$urandom}};
    model(w);
    lat = 0;
    busy_ok = 1;
    for (int k = 1; k <= 30; k++) begin
      go_conv = ghost && (k == 5 || k == 21);
      @(negedge clk_conv);
      if (conv_done) begin
        lat = k;
        break;
      end
      if (!conv_busy) busy_ok = 0;
    end
    go_conv = 1'b0;
    chk({tag, " latency"}, lat, 21);
    chk({tag, " busy-continuous"}, busy_ok, 1);
    chk({tag, " busy-at-done"}, conv_busy, 0);
    chk({tag, " converged"}, converged, mconv);
    chk({tag, " delta_max"}, delta_max, mdmax);
    chk({tag, " iter_cnt"}, iter_cnt, mcnt);
    chk({tag, " iter_limit"}, iter_limit, mlim);
    chk({tag, " w_old"}, w_old_flat, mold);
  endtask
  initial begin
    logic [415:0] w;
    bit seen;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk_conv);
    rstn_conv = 1'b1;
    run("first-I", diag(65536), 0, 0);
    run("second-I", diag(65536), 0, 0);
    run("neg-I", diag(-65536), 0, 0);
    run("restore-I", diag(65536), 0, 0);
    w = diag(65536);
    w[0 +: 26] = 26'd65470;
    run("w11-65470", w, 0, 0);
    run("restore-I2", diag(65536), 0, 0);
    w[0 +: 26] = 26'd65471;
    run("w11-65471", w, 0, 0);
    run("ghost-go", diag(65536), 0, 1);
    @(negedge clk_conv);
    chk("ghost done-low", conv_done, 0);
    chk("ghost busy-low", conv_busy, 0);
    chk("ghost iter_cnt", iter_cnt, mcnt);
    run("b2b-a", diag(-65536), 0, 0);
    run("b2b-b", diag(65536), 1, 0);
    w = {16{26'h2000000}};
    run("sat-1", w, 0, 0);
    run("sat-2", w, 0, 0);
    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin
        w = diag(($urandom_range(0, 1) ? -1 : 1) * (65536 + longint'($urandom_range(0, 160)) - 80));
        for (int k = 0; k < 16; k++)
          if (k % 5 != 0) w[k*26 +: 26] = 26'(longint'($urandom_range(0, 40)) - 20);
      end else w = {13{$urandom}};
      run($sformatf("rand-%0d", r), w, 0, 0);
    end
    run("pre-init-I", diag(65536), 0, 0);
    @(negedge clk_conv);
    init_conv = 1'b1;
    @(negedge clk_conv);
    init_conv = 1'b0;
    mvalid = 0;
    mcnt = 0;
    chk("init iter_cnt", iter_cnt, 0);
    chk("init iter_limit", iter_limit, mlim);
    run("post-init-I", diag(65536), 0, 0);
    @(negedge clk_conv);
    go_conv = 1'b1;
    w_new_flat = diag(65536);
    @(negedge clk_conv);
    go_conv = 1'b0;
    repeat (9) @(negedge clk_conv);
    @(posedge clk_conv);
    #1 rstn_conv = 1'b0;
    #1 chk_zero("mid-reset");
    model_reset();
    repeat (3) @(negedge clk_conv);
    rstn_conv = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_conv);
      if (conv_done || conv_busy) seen = 1;
    end
    chk("mid-reset no-done", seen, 0);
    run("after-reset-I", diag(65536), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/symm_conv_check.md
Name: symm_conv_check

Overview:
- Convergence-test stage directly downstream of the symmetric-orthogonalization stage in the FastICA datapath.
- On each go, it captures the freshly orthogonalized 4x4 W (26-bit signed fixed point) and forms the row-wise dot products with the previous iterate, W_old.
- It flags convergence when every |1 - |w_new_i . w_old_i|| is below a tolerance, counts iterations, and then retires W_new into W_old for the next pass.

Parameters:
- FRAC, 16, fractional bits of the 26-bit signed format; ONE = 1<<FRAC.
- TOL, 66, convergence threshold in LSBs; the test is strictly less-than.
- MAX_ITER, 100, iteration count at which iter_limit asserts.

Ports:
- clk_conv, input, 1, clock, rising edge.
- rstn_conv, input, 1, asynchronous active-low reset.
- go_conv, input, 1, start request; sampled only in IDLE.
- init_conv, input, 1, clears W_old validity and iter_cnt; sampled only in IDLE.
- w_new_flat, input, 416, W_new; element ij occupies bits [(4*(i-1)+(j-1))*26 +: 26], row-major, i,j in 1..4.
- conv_busy, output, 1, high while a check is in progress.
- conv_done, output, 1, single-cycle completion pulse.
- converged, output, 1, result of the last check; held until the next done.
- iter_limit, output, 1, high when iter_cnt >= MAX_ITER; held.
- iter_cnt, output, 8, completed checks since reset/init; saturates at 255.
- delta_max, output, 26, largest row delta from the last check; unsigned magnitude.
- w_old_flat, output, 416, registered W_old, same packing as w_new_flat.

Behaviour:
- Reset (async, rstn_conv low) clears: all outputs 0, w_old_flat 0, w_old_valid 0, state IDLE, all counters 0. Reset mid-check aborts it with no done pulse.
- FSM states: IDLE, MAC, EVAL, FINISH.
- IDLE:
  - If init_conv=1: clear w_old_valid and iter_cnt.
  - If go_conv=1 (same edge; init takes effect first): latch w_new_flat into internal W_new, clear acc/row/col/delta_max, set conv_busy=1, go to MAC.
- MAC: one element per cycle. acc += sext54(w_new_rc * w_old_rc), where the 52-bit signed product is summed into a 54-bit accumulator. col counts 0..3; after col 3, go to EVAL.
- EVAL, one cycle per row:
  - d = acc >>> FRAC (arithmetic), saturated to the 26-bit signed range.
  - a = |d|, where -2^25 saturates to 2^25-1.
  - delta = |ONE - a|.
  - delta_max = max(delta_max, delta).
  - acc is cleared. If row < 3: row++, col = 0, return to MAC. Otherwise go to FINISH.
- FINISH, one cycle:
  - converged <= w_old_valid && (delta_max < TOL).
  - iter_cnt <= sat255(iter_cnt+1); iter_limit <= (new iter_cnt >= MAX_ITER).
  - w_old <= W_new; w_old_valid <= 1.
  - conv_done <= 1, conv_busy <= 0; return to IDLE.
- Timing:
  - Go accepted at edge 0; MAC/EVAL span edges 1..20 (4 rows x 5 cycles); FINISH is edge 21.
  - conv_done is high exactly one cycle, from edge 21 to edge 22, concurrent with conv_busy=0.
  - Go-to-done latency is 21 cycles.
- Handshake boundaries:
  - go_conv and init_conv are ignored while busy.
  - A new go is accepted on edge 22 (while done is high), giving back-to-back operation.
  - w_new_flat need only be valid on the accepting edge.
- First pass (w_old_valid=0): the arithmetic runs against the stale/zero W_old. converged is forced 0, W_old is loaded, and iter_cnt still increments.
- Sign invariance: row dot products of -1 count as converged, because the test uses |d|.
- delta_max, converged and iter_limit change only on FINISH or reset; they are stable between done pulses.

Test Plan:
- Reset, then go with W_new = I (diagonal 65536, others 0) -> done 21 cycles later; converged=0, iter_cnt=1, w_old_flat = I, delta_max = 65536 (W_old was 0).
- Continue with a second go using W_new = I -> converged=1, delta_max=0, iter_cnt=2.
- Then go with W_new = -I -> every d = -65536 and |d| = 65536; converged=1, delta_max=0.
- Sensitivity, with W_old = I:
  - W_new = I but w11 = 65470 -> delta_max=66, converged=0.
  - Repeat from W_old = I with w11 = 65471 -> delta_max=65, converged=1.
- Assert go on edges 5 and 21 during a check -> both ignored; exactly one done pulse; busy is continuous for 21 cycles.
- MAX_ITER=3:
  - Three checks -> iter_limit=1 after the third.
  - init_conv pulsed in IDLE -> iter_cnt=0, iter_limit unchanged until the next FINISH, and the next check reports converged=0.
  - Drop rstn_conv at edge 10 of a check -> no done pulse; all outputs 0 immediately.
